// File: rtl/sm_uart_tx_if.sv
// rtl/sm_uart_tx_if.sv - CPU register bus bundle for the sm_uart_tx transmitter
//
// Signals:
//   bSel   : peripheral selected by the CPU address decode
//   bAddr  : word register offset (0 DATA, 1 STATUS, 2 DIVISOR, 3 CTRL)
//   bWe    : write strobe, qualified by bSel
//   bWData : write data
//   bRData : combinational read data, 0 when not selected
// Modports: master (CPU side), slave (peripheral side).

interface sm_uart_tx_if;
    logic        bSel;
    logic [1:0]  bAddr;
    logic        bWe;
    logic [31:0] bWData;
    logic [31:0] bRData;

    modport master (output bSel, output bAddr, output bWe, output bWData, input bRData);
    modport slave  (input bSel, input bAddr, input bWe, input bWData, output bRData);
endinterface

// File: rtl/sm_uart_tx.sv
// rtl/sm_uart_tx.sv - register-programmed 8N1 UART transmitter with a small transmit FIFO
//
// Parameters:
//   FIFO_DEPTH : transmit FIFO entries (power of two, 2..16)
//   DIV_RESET  : reset value of the DIVISOR register
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : CPU register bus (sm_uart_tx_if.slave)
//   txd  : registered serial output, idle high
//   irq  : registered level interrupt, IRQ_EN & FIFO empty & idle

module sm_uart_tx #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic          clk,
    input  logic          rst,
    sm_uart_tx_if.slave   bus,
    output logic          txd,
    output logic          irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        div_frame_q, div_frame_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               txd_q, txd_d;
    logic               irq_q, irq_d;
    logic [15:0]        divisor_q, divisor_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic               ovf_q, ovf_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];

    logic wr_data, wr_status, wr_div, wr_ctrl;
    logic fifo_full, fifo_empty, busy;
    logic push, pop;

    wire unused_wdata = ^bus.bWData[31:16];

    assign wr_data   = bus.bSel & bus.bWe & (bus.bAddr == 2'd0);
    assign wr_status = bus.bSel & bus.bWe & (bus.bAddr == 2'd1);
    assign wr_div    = bus.bSel & bus.bWe & (bus.bAddr == 2'd2);
    assign wr_ctrl   = bus.bSel & bus.bWe & (bus.bAddr == 2'd3);

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q != ST_IDLE);

    // A full FIFO still accepts a write when the FSM pops in the same cycle.
    assign push = wr_data & (~fifo_full | pop);

    // Frame sequencer. The bit counter counts down from the latched frame
    // divisor, so each bit lasts div_frame_q + 1 clocks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_frame_d = div_frame_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        pop         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0] && !fifo_empty) begin
                    pop         = 1'b1;
                    state_d     = ST_START;
                    div_frame_d = divisor_q;
                    cnt_d       = divisor_q;
                    shreg_d     = mem_q[rd_ptr_q];
                end
            end
            ST_START: begin
                if (cnt_q == 16'd0) begin
                    state_d   = ST_DATA;
                    cnt_d     = div_frame_q;
                    bit_idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = div_frame_q;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // txd is derived from the next state so the registered line changes on
    // the same edge as the state register.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shreg_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping and register writes.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        divisor_d = divisor_q;
        ctrl_d    = ctrl_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.bWData[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (wr_status) begin
            ovf_d = 1'b0;
        end else if (wr_data && !push) begin
            ovf_d = 1'b1;
        end
        if (wr_div) begin
            divisor_d = bus.bWData[15:0];
        end
        if (wr_ctrl) begin
            ctrl_d = bus.bWData[1:0];
        end
    end

    assign irq_d = ctrl_q[1] & fifo_empty & ~busy;

    always_comb begin
        bus.bRData = 32'd0;
        if (bus.bSel) begin
            case (bus.bAddr)
                2'd1:    bus.bRData = {23'd0, 5'(count_q), ovf_q, busy, fifo_empty, fifo_full};
                2'd2:    bus.bRData = {16'd0, divisor_q};
                2'd3:    bus.bRData = {30'd0, ctrl_q};
                default: bus.bRData = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            div_frame_q <= 16'd0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'd0;
            txd_q       <= 1'b1;
            irq_q       <= 1'b0;
            divisor_q   <= DIV_RESET;
            ctrl_q      <= 2'd0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_frame_q <= div_frame_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            txd_q       <= txd_d;
            irq_q       <= irq_d;
            divisor_q   <= divisor_d;
            ctrl_q      <= ctrl_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign txd = txd_q;
    assign irq = irq_q;

endmodule
